wb_arbiter: RTL and testbench

- Shares the register file's single write port (wenable/wfmode/wreg/wdata) between NREQ writeback sources, e.g. ALU, FPU and load unit.
- Each source offers one write per transaction via valid/ready.
- The arbiter picks one source per cycle by round-robin and drives the write port from a registered stage, one cycle after acceptance.
- Sits between the execution units and the register file in the core.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/wb_arbiter.sv | 82 ++++++++
 tb/tb_wb_arbiter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants, the writeback payload type and the round-robin pointer helper
// for the register-file writeback arbiter.
package wb_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int WB_DATA_W  = 32;

  typedef struct packed {
    logic                  fmode;
    logic [REG_IDX_W-1:0]  regidx;
    logic [WB_DATA_W-1:0]  data;
  } wb_req_t;

  // Index of the requester that follows idx in round-robin order.
  function automatic int next_ptr(input int idx, input int nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Requester handshake plus register-file write port of the writeback arbiter.
// The arbiter takes the slave side; the execution units and register file the master side.
interface wb_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32
);
  import wb_pkg::*;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           req_fmode;
  logic [NREQ*REG_IDX_W-1:0] req_reg;
  logic [NREQ*DATA_W-1:0]    req_data;

  logic                      wenable;
  logic                      wfmode;
  logic [REG_IDX_W-1:0]      wreg;
  logic [DATA_W-1:0]         wdata;

  modport slave (
    input  req_valid, req_fmode, req_reg, req_data,
    output req_ready, wenable, wfmode, wreg, wdata
  );

  modport master (
    output req_valid, req_fmode, req_reg, req_data,
    input  req_ready, wenable, wfmode, wreg, wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_any
);

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req[(int'(ptr) + k) % NREQ]) begin
        grant_any                       = 1'b1;
        grant[(int'(ptr) + k) % NREQ]   = 1'b1;
        grant_idx                       = PTR_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ writeback sources.
// Optional grant/conflict counters are built when WB_ARB_PERF_CNT_EN is defined.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  wb_arbiter_if.slave        bus
`ifdef WB_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        grant_cnt,
  output logic [31:0]        conflict_cnt
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;
  logic             accept;

  logic                 sel_fmode;
  logic [REG_IDX_W-1:0] sel_reg;
  logic [DATA_W-1:0]    sel_data;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready depends only on valid and the pointer; reset blocks every acceptance.
  assign bus.req_ready = rst ? '0 : grant;
  assign accept        = grant_any && !rst;

  assign sel_fmode = bus.req_fmode[grant_idx];
  assign sel_reg   = bus.req_reg[int'(grant_idx)*REG_IDX_W +: REG_IDX_W];
  assign sel_data  = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wenable <= 1'b0;
      bus.wfmode  <= 1'b0;
      bus.wreg    <= '0;
      bus.wdata   <= '0;
      rr_ptr      <= '0;
    end else begin
      bus.wenable <= 1'b0;
      if (accept) begin
        bus.wfmode  <= sel_fmode;
        bus.wreg    <= sel_reg;
        bus.wdata   <= sel_data;
        // Integer r0 is hardwired zero: consume the write but never strobe it.
        bus.wenable <= sel_fmode || (sel_reg != '0);
        rr_ptr      <= PTR_W'(next_ptr(int'(grant_idx), NREQ));
      end
    end
  end

`ifdef WB_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (accept)
        grant_cnt <= grant_cnt + 32'd1;
      if (|(bus.req_valid & ~grant))
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter: the driver checks ready and queues the expected
// registered write; a monitor pops and compares after each clock edge.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int NREQ   = 3;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic    en;
    wb_req_t w;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

`ifdef WB_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt;
  logic [31:0] conflict_cnt;
`endif

  wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave)
`ifdef WB_ARB_PERF_CNT_EN
    ,
    .grant_cnt    (grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Default payloads: r0 int x5, r1 float x9, r2 int x17.
  localparam logic [2:0]  F_DEF = 3'b010;
  localparam logic [14:0] R_DEF = {5'd17, 5'd9, 5'd5};
  localparam logic [95:0] D_DEF = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

  // One cycle of stimulus: drive, check combinational ready, queue the write expected next cycle.
  task automatic cyc(input logic r, input logic [2:0] v, input logic [2:0] f,
                     input logic [14:0] rg, input logic [95:0] d, input logic [2:0] exp_rdy,
                     input logic e_en, input logic e_f, input logic [4:0] e_reg,
                     input logic [31:0] e_data);
    exp_t e;
    @(posedge clk);
    #2;
    rst           = r;
    bus.req_valid = v;
    bus.req_fmode = f;
    bus.req_reg   = rg;
    bus.req_data  = d;
    #1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    e.en       = e_en;
    e.w.fmode  = e_f;
    e.w.regidx = e_reg;
    e.w.data   = e_data;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wenable", 32'(bus.wenable), 32'(e.en));
        check("wfmode",  32'(bus.wfmode),  32'(e.w.fmode));
        check("wreg",    32'(bus.wreg),    32'(e.w.regidx));
        check("wdata",   bus.wdata,        e.w.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_fmode = '0;
    bus.req_reg   = '0;
    bus.req_data  = '0;

    // Reset, then a single request from requester 0.
    cyc(1, 3'b000, F_DEF, R_DEF, D_DEF, 3'b000, 0, 0, 5'd0,  32'h0);
    cyc(1, 3'b000, F_DEF, R_DEF, D_DEF, 3'b000, 0, 0, 5'd0,  32'h0);
    cyc(0, 3'b001, F_DEF, R_DEF, D_DEF, 3'b001, 1, 0, 5'd5,  32'hDEAD_BEEF);
    cyc(0, 3'b000, F_DEF, R_DEF, D_DEF, 3'b000, 0, 0, 5'd5,  32'hDEAD_BEEF);

    // Full contention from rr_ptr=0 (reset cycle puts pointer and counters at 0).
    cyc(1, 3'b111, F_DEF, R_DEF, D_DEF, 3'b000, 0, 0, 5'd0,  32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 3'b111, F_DEF, R_DEF, D_DEF, 3'b001, 1, 0, 5'd5,  32'hDEAD_BEEF);
      cyc(0, 3'b111, F_DEF, R_DEF, D_DEF, 3'b010, 1, 1, 5'd9,  32'h1111_1111);
      cyc(0, 3'b111, F_DEF, R_DEF, D_DEF, 3'b100, 1, 0, 5'd17, 32'h2222_2222);
    end

    // Integer r0 from requester 1 is consumed silently (ptr 0 -> 2); float r0 is written.
    cyc(0, 3'b010, 3'b000, {5'd17, 5'd0, 5'd5}, D_DEF, 3'b010, 0, 0, 5'd0, 32'h1111_1111);
`ifdef WB_ARB_PERF_CNT_EN
    check("grant_cnt",    grant_cnt,    32'd6);
    check("conflict_cnt", conflict_cnt, 32'd6);
`endif
    cyc(0, 3'b010, 3'b010, {5'd17, 5'd0, 5'd5}, D_DEF, 3'b010, 1, 1, 5'd0, 32'h1111_1111);

    // Wrap: requester 2 alone (ptr -> 0), then all valid picks requester 0, then idle holds.
    cyc(0, 3'b100, F_DEF, R_DEF, D_DEF, 3'b100, 1, 0, 5'd17, 32'h2222_2222);
    cyc(0, 3'b111, F_DEF, R_DEF, D_DEF, 3'b001, 1, 0, 5'd5,  32'hDEAD_BEEF);
    cyc(0, 3'b000, F_DEF, R_DEF, D_DEF, 3'b000, 0, 0, 5'd5,  32'hDEAD_BEEF);
    cyc(0, 3'b000, F_DEF, R_DEF, D_DEF, 3'b000, 0, 0, 5'd5,  32'hDEAD_BEEF);

    // Reset mid-stream: grant to requester 1 in flight, then reset drops it.
    cyc(0, 3'b111, F_DEF, R_DEF, D_DEF, 3'b010, 1, 1, 5'd9,  32'h1111_1111);
    cyc(1, 3'b111, F_DEF, R_DEF, D_DEF, 3'b000, 0, 0, 5'd0,  32'h0);
    cyc(0, 3'b111, F_DEF, R_DEF, D_DEF, 3'b001, 1, 0, 5'd5,  32'hDEAD_BEEF);
`ifdef WB_ARB_PERF_CNT_EN
    check("grant_cnt_rst",    grant_cnt,    32'd0);
    check("conflict_cnt_rst", conflict_cnt, 32'd0);
`endif
    cyc(0, 3'b000, F_DEF, R_DEF, D_DEF, 3'b000, 0, 0, 5'd5,  32'hDEAD_BEEF);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
